mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 169 ++++++++++++++++
 tb/tb_mem_lsu.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit for the MEM stage.
// Issues one data-memory request per load/store, stalls the pipeline until the
// memory completes, formats load results and lane-aligns store data/strobes.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   M_ALUResult       effective byte address
//   M_WriteData       store data, right-aligned
//   M_MemRead/Write   load / store request (store wins when both set)
//   M_Funct3          access size/sign (B, H, W, BU, HU; 011/110/111 act as W)
//   M_ReadData        formatted load result (valid in DONE, else 0)
//   M_Stall           combinational pipeline hold
//   M_MisalignErr     misaligned-access flag (0 unless trap build)
//   dmem_*            registered memory request bus; dmem_ready/dmem_rdata return
//
// Build option: define MEM_LSU_MISALIGN_TRAP_EN to flag misaligned H/W accesses
// instead of truncating them to natural alignment.
module mem_lsu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] M_ALUResult,
  input  logic [DATA_WIDTH-1:0] M_WriteData,
  input  logic                  M_MemRead,
  input  logic                  M_MemWrite,
  input  logic [2:0]            M_Funct3,
  output logic [DATA_WIDTH-1:0] M_ReadData,
  output logic                  M_Stall,
  output logic                  M_MisalignErr,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_wstrb,
  input  logic                  dmem_ready,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     wstrb;
  } dmem_cmd_t;

  state_t                state, state_nxt;
  dmem_cmd_t             cmd, cmd_nxt;
  logic                  req, req_nxt;
  logic [DATA_WIDTH-1:0] cap, cap_nxt;

  logic [1:0]            lane;
  logic                  is_byte, is_half, is_unsigned, is_store;
  logic                  mem_op, access;
  logic [DATA_WIDTH-1:0] st_wdata, ld_data;
  logic [STRB_W-1:0]     st_wstrb;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  // Access decode; any funct3 that is not B/H/BU/HU behaves as a word
  assign lane        = M_ALUResult[1:0];
  assign is_byte     = (M_Funct3[1:0] == 2'b00);
  assign is_half     = (M_Funct3[1:0] == 2'b01);
  assign is_unsigned = M_Funct3[2];
  assign is_store    = M_MemWrite;
  assign mem_op      = M_MemRead | M_MemWrite;

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned    = (is_half & lane[0]) | (~is_byte & ~is_half & (lane != 2'b00));
  assign access        = mem_op & ~misaligned;
  // Gated by rst_n so the flag is forced low while reset is asserted
  assign M_MisalignErr = rst_n & mem_op & misaligned;
`else
  assign access        = mem_op;
  assign M_MisalignErr = 1'b0;
`endif

  assign M_Stall = access & (state != DONE);

  // Store lane replication and strobes; H uses addr[1] only, W ignores lane
  always_comb begin
    st_wdata = M_WriteData;
    st_wstrb = '1;
    if (is_byte) begin
      st_wdata = DATA_WIDTH'({4{M_WriteData[7:0]}});
      st_wstrb = STRB_W'(4'b0001) << lane;
    end else if (is_half) begin
      st_wdata = DATA_WIDTH'({2{M_WriteData[15:0]}});
      st_wstrb = lane[1] ? STRB_W'(4'b1100) : STRB_W'(4'b0011);
    end
  end

  // Load lane select and extension from the captured word
  always_comb begin
    ld_byte = cap[{lane, 3'b000} +: 8];
    ld_half = cap[{lane[1], 4'b0000} +: 16];
    ld_data = cap;
    if (is_byte) begin
      ld_data = is_unsigned ? DATA_WIDTH'({24'd0, ld_byte})
                            : DATA_WIDTH'({{24{ld_byte[7]}}, ld_byte});
    end else if (is_half) begin
      ld_data = is_unsigned ? DATA_WIDTH'({16'd0, ld_half})
                            : DATA_WIDTH'({{16{ld_half[15]}}, ld_half});
    end
  end

  assign M_ReadData = (state == DONE && access && !is_store) ? ld_data : '0;

  // State and request bus registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cmd   <= '0;
      req   <= 1'b0;
      cap   <= '0;
    end else begin
      state <= state_nxt;
      cmd   <= cmd_nxt;
      req   <= req_nxt;
      cap   <= cap_nxt;
    end
  end

  // Next-state and request bus updates
  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd;
    req_nxt   = req;
    cap_nxt   = cap;
    case (state)
      IDLE: begin
        if (access) begin
          req_nxt       = 1'b1;
          cmd_nxt.addr  = {M_ALUResult[ADDR_WIDTH-1:2], 2'b00};
          cmd_nxt.we    = is_store;
          cmd_nxt.wdata = is_store ? st_wdata : '0;
          cmd_nxt.wstrb = is_store ? st_wstrb : '0;
          state_nxt     = REQ;
        end
      end
      REQ: begin
        if (dmem_ready) begin
          cap_nxt   = dmem_rdata;
          req_nxt   = 1'b0;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign dmem_req   = req;
  assign dmem_we    = cmd.we;
  assign dmem_addr  = cmd.addr;
  assign dmem_wdata = cmd.wdata;
  assign dmem_wstrb = cmd.wstrb;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed and randomized checks of mem_lsu against a
// transaction-level reference model (access size/sign rules, lane math).
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] M_ALUResult, M_WriteData, M_ReadData;
  logic        M_MemRead, M_MemWrite, M_Stall, M_MisalignErr;
  logic [2:0]  M_Funct3;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .M_ALUResult(M_ALUResult), .M_WriteData(M_WriteData),
    .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .M_Funct3(M_Funct3),
    .M_ReadData(M_ReadData), .M_Stall(M_Stall), .M_MisalignErr(M_MisalignErr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Access size in bytes and signedness from funct3
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit signed_of(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001);
  endfunction

  function automatic bit trap_of(input logic [2:0] f3, input logic [31:0] addr);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    return (addr % size_of(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Byte offset inside the word after natural-alignment truncation
  function automatic int off_of(input logic [2:0] f3, input logic [31:0] addr);
    int sz = size_of(f3);
    return ((addr % 4) / sz) * sz;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int sz = size_of(f3);
    logic [31:0] v;
    v = word >> (8 * off_of(f3, addr));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (signed_of(f3) && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (signed_of(f3) && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
    int sz = size_of(f3);
    return 4'(((1 << sz) - 1) << off_of(f3, addr));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz = size_of(f3);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < 4; i++) v = v | (((d >> (8 * (i % sz))) & 32'hFF) << (8 * i));
    return v;
  endfunction

  // Runs one MEM-stage instruction; starts and ends away from the rising edge
  task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int waits, input logic [31:0] word,
                         output logic [31:0] o_rd, output int o_stall);
    bit          trap, access, store, done;
    int          reqn;
    logic [31:0] e_rd;
    trap   = (rd | wr) && trap_of(f3, addr);
    access = (rd | wr) && !trap;
    store  = wr;
    e_rd   = (access && !store) ? model_load(f3, addr, word) : 32'd0;
    M_MemRead = rd; M_MemWrite = wr; M_Funct3 = f3;
    M_ALUResult = addr; M_WriteData = wd;
    dmem_ready = 1'b0;
    #1;
    check("misalign_err", 32'(M_MisalignErr), 32'(trap));
    reqn = 0; done = 1'b0; o_stall = 0; o_rd = 32'd0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (dmem_req) begin
        check("dmem_addr", dmem_addr, addr & 32'hFFFF_FFFC);
        check("dmem_we", 32'(dmem_we), 32'(store));
        if (store) begin
          check("dmem_wstrb", 32'(dmem_wstrb), 32'(model_strb(f3, addr)));
          check("dmem_wdata", dmem_wdata, model_wdata(f3, wd));
        end
        dmem_ready = (reqn == waits);
        dmem_rdata = (reqn == waits) ? word : $urandom;
        reqn++;
      end else begin
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
      end
      if (!M_Stall) begin
        done = 1'b1;
        o_rd = M_ReadData;
        check("read_data", M_ReadData, e_rd);
        check("req_dropped", 32'(dmem_req), 32'd0);
      end else begin
        o_stall++;
        @(negedge clk); #1;
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    check("stall_cycles", 32'(o_stall), access ? 32'(waits + 2) : 32'd0);
    check("req_cycles", 32'(reqn), access ? 32'(waits + 1) : 32'd0);
    @(negedge clk); #1;
  endtask

  logic [31:0] got_rd;
  int          got_st;

  initial begin
    rst_n = 1'b0;
    M_MemRead = 1'b0; M_MemWrite = 1'b0; M_Funct3 = 3'd0;
    M_ALUResult = 32'd0; M_WriteData = 32'd0;
    dmem_ready = 1'b0; dmem_rdata = 32'd0;
    #12;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(M_Stall), 32'd0);
    check("rst_rdata", M_ReadData, 32'd0);
    check("rst_err", 32'(M_MisalignErr), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;

    // LB at lane 3, sign-extended, ready on first REQ cycle
    run_txn(1, 0, 3'b000, 32'h103, 32'd0, 0, 32'h80FF_0000, got_rd, got_st);
    check("lb_rd", got_rd, 32'hFFFF_FF80);
    check("lb_stall", 32'(got_st), 32'd2);
    // LHU upper half, three wait cycles
    run_txn(1, 0, 3'b101, 32'h202, 32'd0, 3, 32'hBEEF_1234, got_rd, got_st);
    check("lhu_rd", got_rd, 32'h0000_BEEF);
    check("lhu_stall", 32'(got_st), 32'd5);
    // SB to lane 1
    run_txn(0, 1, 3'b000, 32'h11, 32'h0000_00A5, 1, 32'h1357_9BDF, got_rd, got_st);
    check("sb_rd", got_rd, 32'd0);
    // LW at 0x2: trapped or truncated
    run_txn(1, 0, 3'b010, 32'h2, 32'd0, 0, 32'h1234_5678, got_rd, got_st);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    check("lw_mis_rd", got_rd, 32'd0);
    check("lw_mis_stall", 32'(got_st), 32'd0);
`else
    check("lw_mis_rd", got_rd, 32'h1234_5678);
    check("lw_mis_stall", 32'(got_st), 32'd2);
`endif
    // Non-access passes through; funct3 111 store behaves as SW
    run_txn(0, 0, 3'b010, 32'h40, 32'd0, 0, 32'hFFFF_FFFF, got_rd, got_st);
    check("nop_stall", 32'(got_st), 32'd0);
    run_txn(1, 1, 3'b111, 32'h84, 32'hCAFE_F00D, 2, 32'h5555_AAAA, got_rd, got_st);
    run_txn(1, 0, 3'b001, 32'h306, 32'd0, 0, 32'h8001_7FFF, got_rd, got_st);
    check("lh_rd", got_rd, 32'hFFFF_8001);

    // Reset in REQ, then a stray ready
    M_MemRead = 1'b1; M_MemWrite = 1'b0; M_Funct3 = 3'b010; M_ALUResult = 32'h400;
    dmem_ready = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    check("pre_rst_req", 32'(dmem_req), 32'd1);
    rst_n = 1'b0; #1;
    check("midrst_req", 32'(dmem_req), 32'd0);
    check("midrst_addr", dmem_addr, 32'd0);
    M_MemRead = 1'b0; #1;
    check("midrst_stall", 32'(M_Stall), 32'd0);
    dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    check("stray_req", 32'(dmem_req), 32'd0);
    check("stray_stall", 32'(M_Stall), 32'd0);
    check("stray_rd", M_ReadData, 32'd0);
    dmem_ready = 1'b0;
    run_txn(1, 0, 3'b010, 32'h500, 32'd0, 0, 32'h0BAD_F00D, got_rd, got_st);
    check("post_rst_stall", 32'(got_st), 32'd2);

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      bit          r_rd, r_wr;
      logic [2:0]  r_f3;
      logic [31:0] r_addr, r_wd, r_word;
      int          r_w;
      r_rd   = 1'($urandom_range(0, 1));
      r_wr   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = $urandom;
      r_wd   = $urandom;
      r_word = $urandom;
      r_w    = int'($urandom_range(0, 3));
      run_txn(r_rd, r_wr, r_f3, r_addr, r_wd, r_w, r_word, got_rd, got_st);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
